nmr_bstrm_multich_dpath: RTL and testbench
==========================================

# nmr_bstrm_multich_dpath

Multi-channel, FIFO-fed successor to the single-pulse bitstream datapath in the NMR pulse-sequencer chain. Accepts a stream of pulse entries (length, per-channel polarity vector, last flag) over a valid/ready handshake and plays them back-to-back with no inter-entry gap on `NCH` outputs. Each output has its own 4-bit selector that routes either the sequencer bit or one external `mux_in` line.

## Interface
- `DATA_WIDTH`, 24: pulse-length width in cycles.
- `NCH`, 4: number of output channels.
- `DEPTH`, 8: entry FIFO depth; power of 2, ≥2.
- `MUX_WIDTH`, 16: mux inputs per channel; `mux_in` per channel is `MUX_WIDTH-1` bits.
- `IDLE_POL`, `{NCH{1'b0}}`: per-channel sequencer level when not playing.
- `CLK  in  1`: single clock, all logic on posedge.
- `RST  in  1`: reset, synchronous, active-high.
- `START  in  1`: begin playback; sampled only in IDLE.
- `ABORT  in  1`: synchronous abort; flushes FIFO, returns to IDLE.
- `in_valid  in  1` / `in_ready  out  1`: entry handshake; transfer when both high.
- `in_len  in  DATA_WIDTH`: entry length in cycles; 0 treated as 1.
- `in_pol  in  NCH`: sequencer level per channel during the entry.
- `in_last  in  1`: entry ends the sequence.
- `mux_sel  in  4*NCH`: channel c uses bits `[4c+3:4c]`.
- `mux_in  in  (MUX_WIDTH-1)*NCH`: channel c uses bits `[(MUX_WIDTH-1)(c+1)-1:(MUX_WIDTH-1)c]`.
- `BUSY  out  1`: high in RUN.
- `DONE  out  1`: one-cycle pulse after the last entry completes.
- `UNDERRUN  out  1`: sticky underrun flag (see Configuration).
- `fifo_cnt  out  $clog2(DEPTH)+1`: current FIFO occupancy.
- `OUT  out  NCH`: channel outputs.

## Operation
- FIFO: `in_ready = !full`, writes accepted in any state except the ABORT cycle. Push and pop in one cycle allowed when not full; count unchanged.
- States: IDLE, RUN.
- IDLE: sequencer bits = `IDLE_POL`. On `START` with FIFO non-empty: latch `mux_sel` into `mux_sel_reg`, pop entry, load counter with `max(len,1)`, drive `in_pol`, go to RUN. `START` with FIFO empty is ignored.
- RUN: counter decrements each cycle. On the final cycle (counter = 1):
  - last flag set: DONE next cycle, bits to `IDLE_POL`, go to IDLE;
  - else FIFO non-empty: pop, reload, new polarity on the next cycle with no gap;
  - else underrun: bits to `IDLE_POL`, go to IDLE, set UNDERRUN (if compiled in).
- Counter is `DATA_WIDTH` bits, loaded with `len` (or 1), never wraps; len `2^DATA_WIDTH-1` is honoured exactly.
- Output mux per channel: sel 0 → sequencer bit; sel k in 1..`MUX_WIDTH-1` → `mux_in[k-1]` of that channel; other values → 0. Combinational from `mux_sel_reg` and `mux_in`.
- ABORT (any state, priority over START and push): FIFO emptied, state IDLE, bits to `IDLE_POL`, no DONE. UNDERRUN is not cleared.

## Timing
- Reset values: state IDLE, FIFO empty, `fifo_cnt`=0, `in_ready`=1, `BUSY`=0, `DONE`=0, `UNDERRUN`=0, `mux_sel_reg`=0, sequencer bits = `IDLE_POL`, so `OUT`=`IDLE_POL`.
- RST mid-sequence behaves identically to reset from idle; no DONE.
- START sampled at edge t: entry polarity visible on cycles t+1 … t+len. BUSY high over the same cycles.
- Back-to-back entries are contiguous: entry n+1 starts the cycle after entry n ends.
- DONE high on cycle t+Σlen+1 only, coincident with return to `IDLE_POL`.
- A pushed entry is poppable the cycle after the push edge; no fall-through.

## Configuration
- `NMR_BSTRM_UNDERRUN_EN` defined: underrun detection compiled in. `UNDERRUN` is set on the underrun event and cleared only by RST or by a START accepted in IDLE.
- Not defined: `UNDERRUN` tied 0. Underrun still ends playback silently, returning to IDLE with no DONE.

## Structure
- Package `nmr_bstrm_pkg` holds:
  - state typedef (IDLE, RUN);
  - the mux-select width constant (4);
  - the function computing the entry packing width `DATA_WIDTH+NCH+1`.
- Sub-module `nmr_bstrm_fifo`: synchronous FIFO, parametrised width/depth, with count, full, empty and flush ports.

## Test plan
- Entries (3, `4'b0101`, 0), (2, `4'b1010`, 1), all sel=0, START: OUT=0101 ×3 cycles then 1010 ×2, then 0000 with DONE for exactly 1 cycle.
- Entry len=0 with last: exactly one cycle of polarity, then DONE.
- Single non-last entry (4, `4'b1111`), FIFO empty: 4 cycles high, then idle with no DONE. UNDERRUN=1 with macro, 0 without.
- Push `DEPTH` entries without START: `in_ready`=0, `fifo_cnt`=DEPTH; a push attempt while full leaves count and contents unchanged.
- ABORT mid-RUN with 3 queued entries: next cycle OUT=`IDLE_POL`, `fifo_cnt`=0, no DONE; a fresh sequence then plays correctly.
- Channel 2 sel=5 latched at START: OUT[2] follows channel 2 `mux_in[4]`. A sel change during RUN has no effect until the next START.

Source files
------------

// File: rtl/nmr_bstrm_pkg.sv
// Shared types and sizing helpers for the multi-channel NMR bitstream datapath.
package nmr_bstrm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MUX_SEL_W = 4;

    // Entry packing in the FIFO: {len, pol, last}
    function automatic int entry_w(input int data_width, input int nch);
        return data_width + nch + 1;
    endfunction

endpackage

// File: rtl/nmr_bstrm_fifo.sv
// Synchronous FIFO with occupancy count and flush; read data is the head entry (no fall-through).
module nmr_bstrm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        wr_en    = push && !full && !flush;
        rd_en    = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/nmr_bstrm_multich_dpath.sv
// FIFO-fed multi-channel pulse player with per-channel output mux.
// Optional sticky underrun flag compiled in with NMR_BSTRM_UNDERRUN_EN.
module nmr_bstrm_multich_dpath
    import nmr_bstrm_pkg::*;
#(
    parameter int             DATA_WIDTH = 24,
    parameter int             NCH        = 4,
    parameter int             DEPTH      = 8,
    parameter int             MUX_WIDTH  = 16,
    parameter logic [NCH-1:0] IDLE_POL   = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_len,
    input  logic [NCH-1:0]               in_pol,
    input  logic                         in_last,
    input  logic [MUX_SEL_W*NCH-1:0]     mux_sel,
    input  logic [(MUX_WIDTH-1)*NCH-1:0] mux_in,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         UNDERRUN,
    output logic [$clog2(DEPTH):0]       fifo_cnt,
    output logic [NCH-1:0]               OUT
);
    localparam int EW  = entry_w(DATA_WIDTH, NCH);
    localparam int MIW = MUX_WIDTH - 1;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
    logic [NCH-1:0]           pol_q, pol_d;
    logic                     last_q, last_d;
    logic [MUX_SEL_W*NCH-1:0] sel_q, sel_d;
    logic                     done_q, done_d;

    logic [EW-1:0]            fifo_rdata;
    logic                     fifo_full, fifo_empty, push, pop;
    logic [DATA_WIDTH-1:0]    rd_len, load_len;
    logic [NCH-1:0]           seq;

    assign push   = in_valid && !fifo_full && !ABORT;
    assign rd_len = fifo_rdata[EW-1 -: DATA_WIDTH];
    // A zero-length entry still occupies one cycle.
    assign load_len = (rd_len == '0) ? DATA_WIDTH'(1) : rd_len;

    nmr_bstrm_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (ABORT),
        .push  (push),
        .pop   (pop),
        .wdata ({in_len, in_pol, in_last}),
        .rdata (fifo_rdata),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef NMR_BSTRM_UNDERRUN_EN
    logic und_q, und_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pol_d   = pol_q;
        last_d  = last_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef NMR_BSTRM_UNDERRUN_EN
        und_d   = und_q;
`endif
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START && !fifo_empty) begin
                        pop     = 1'b1;
                        sel_d   = mux_sel;
                        cnt_d   = load_len;
                        pol_d   = fifo_rdata[NCH:1];
                        last_d  = fifo_rdata[0];
                        state_d = ST_RUN;
`ifdef NMR_BSTRM_UNDERRUN_EN
                        und_d   = 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (cnt_q == DATA_WIDTH'(1)) begin
                        if (last_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else if (!fifo_empty) begin
                            // Reload on the final cycle so the next entry is contiguous.
                            pop    = 1'b1;
                            cnt_d  = load_len;
                            pol_d  = fifo_rdata[NCH:1];
                            last_d = fifo_rdata[0];
                        end else begin
                            state_d = ST_IDLE;
`ifdef NMR_BSTRM_UNDERRUN_EN
                            und_d   = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pol_q   <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pol_q   <= pol_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

`ifdef NMR_BSTRM_UNDERRUN_EN
    always_ff @(posedge CLK) begin
        if (RST) und_q <= 1'b0;
        else     und_q <= und_d;
    end
    assign UNDERRUN = und_q;
`else
    assign UNDERRUN = 1'b0;
`endif

    assign in_ready = !fifo_full;
    assign BUSY     = (state_q == ST_RUN);
    assign DONE     = done_q;
    assign seq      = (state_q == ST_RUN) ? pol_q : IDLE_POL;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [MUX_SEL_W-1:0] sel;
        logic [MIW-1:0]       mi;
        logic                 o;
        assign sel = sel_q[MUX_SEL_W*c +: MUX_SEL_W];
        assign mi  = mux_in[MIW*c +: MIW];
        always_comb begin
            o = 1'b0;
            if (sel == '0) o = seq[c];
            for (int k = 1; k < MUX_WIDTH; k++) begin
                if (sel == MUX_SEL_W'(k)) o = mi[k-1];
            end
        end
        assign OUT[c] = o;
    end

endmodule

// File: tb/tb_nmr_bstrm_multich_dpath.sv
// Randomized + directed bench for nmr_bstrm_multich_dpath against a queue-based playback model.
module tb_nmr_bstrm_multich_dpath;
    localparam int DW = 24, NCH = 4, DEPTH = 8, MW = 16, MIW = MW - 1, CW = $clog2(DEPTH) + 1;
`ifdef NMR_BSTRM_UNDERRUN_EN
    localparam bit UND_EN = 1'b1;
`else
    localparam bit UND_EN = 1'b0;
`endif

    logic              CLK = 0, RST = 1, START = 0, ABORT = 0, in_valid = 0, in_last = 0;
    logic [DW-1:0]     in_len = '0;
    logic [NCH-1:0]    in_pol = '0;
    logic [4*NCH-1:0]  mux_sel = '0;
    logic [MIW*NCH-1:0] mux_in = '0;
    logic              in_ready, BUSY, DONE, UNDERRUN;
    logic [CW-1:0]     fifo_cnt;
    logic [NCH-1:0]    OUT;

    int checks = 0, errors = 0;

    nmr_bstrm_multich_dpath #(
        .DATA_WIDTH(DW), .NCH(NCH), .DEPTH(DEPTH), .MUX_WIDTH(MW), .IDLE_POL(4'b0000)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .in_valid(in_valid), .in_ready(in_ready), .in_len(in_len), .in_pol(in_pol),
        .in_last(in_last), .mux_sel(mux_sel), .mux_in(mux_in),
        .BUSY(BUSY), .DONE(DONE), .UNDERRUN(UNDERRUN), .fifo_cnt(fifo_cnt), .OUT(OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: pending entries in a queue, the playing entry as remaining cycles.
    typedef struct { int unsigned len; logic [3:0] pol; bit last; } ent_t;
    ent_t        q[$];
    bit          m_valid = 0, m_play = 0, m_done = 0, m_und = 0, m_last = 0;
    int unsigned m_rem = 0;
    logic [3:0]  m_pol = '0;
    logic [15:0] m_sel = '0;

    task automatic m_load(input ent_t e);
        m_rem  = (e.len == 0) ? 1 : e.len;
        m_pol  = e.pol;
        m_last = e.last;
    endtask

    always @(posedge CLK) begin
        bit   push_ok;
        ent_t e;
        push_ok = in_valid && (q.size() < DEPTH) && !ABORT;
        m_valid = 1;
        if (RST) begin
            q.delete(); m_play = 0; m_done = 0; m_und = 0; m_sel = '0;
        end else begin
            m_done = 0;
            if (ABORT) begin
                q.delete(); m_play = 0;
            end else begin
                if (!m_play) begin
                    if (START && q.size() > 0) begin
                        e = q.pop_front(); m_load(e);
                        m_sel = mux_sel; m_play = 1; m_und = 0;
                    end
                end else if (m_rem > 1) m_rem--;
                else if (m_last) begin m_play = 0; m_done = 1; end
                else if (q.size() > 0) begin e = q.pop_front(); m_load(e); end
                else begin m_play = 0; if (UND_EN) m_und = 1; end
                if (push_ok) q.push_back('{int'(in_len), in_pol, in_last});
            end
        end
    end

    function automatic logic [3:0] exp_out();
        logic [3:0] r;
        int s;
        for (int c = 0; c < NCH; c++) begin
            s = int'(m_sel[4*c +: 4]);
            if (s == 0) r[c] = m_play ? m_pol[c] : 1'b0;
            else        r[c] = mux_in[MIW*c + s - 1];
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("busy",     BUSY,     m_play);
            chk("done",     DONE,     m_done);
            chk("underrun", UNDERRUN, m_und);
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("fifo_cnt", fifo_cnt, q.size());
            chk("out",      OUT,      exp_out());
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask
    task automatic push(input int unsigned len, input logic [3:0] pol, input bit last);
        in_valid = 1; in_len = len[DW-1:0]; in_pol = pol; in_last = last;
        tick();
        in_valid = 0;
    endtask
    task automatic start();
        START = 1; tick(); START = 0;
    endtask

    initial begin
        logic [3:0] o_tr [7];
        logic       d_tr [7];
        logic [3:0] o_exp [7];
        logic       d_exp [7];
        o_exp = '{4'h5, 4'h5, 4'h5, 4'hA, 4'hA, 4'h0, 4'h0};
        d_exp = '{0, 0, 0, 0, 0, 1, 0};

        tick(); tick();
        @(negedge CLK);
        chk("lit_rst_out", OUT, 4'h0);
        chk("lit_rst_ready", in_ready, 1'b1);
        chk("lit_rst_cnt", fifo_cnt, 0);
        chk("lit_rst_busy", BUSY, 1'b0);
        chk("lit_rst_done", DONE, 1'b0);
        chk("lit_rst_und", UNDERRUN, 1'b0);
        tick(); RST = 0;

        // Two-entry sequence
        push(3, 4'b0101, 0);
        push(2, 4'b1010, 1);
        start();
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK); o_tr[i] = OUT; d_tr[i] = DONE;
        end
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("lit_seq_out%0d", i), o_tr[i], o_exp[i]);
            chk($sformatf("lit_seq_done%0d", i), d_tr[i], d_exp[i]);
        end
        tick();

        // Zero length entry
        push(0, 4'hF, 1);
        start();
        @(negedge CLK); chk("lit_len0_out", OUT, 4'hF); chk("lit_len0_busy", BUSY, 1'b1);
        @(negedge CLK); chk("lit_len0_idle", OUT, 4'h0); chk("lit_len0_done", DONE, 1'b1);
        tick();

        // Underrun
        push(4, 4'hF, 0);
        start();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); chk("lit_und_high", OUT, 4'hF);
        end
        @(negedge CLK);
        chk("lit_und_out", OUT, 4'h0); chk("lit_und_done", DONE, 1'b0);
        chk("lit_und_busy", BUSY, 1'b0); chk("lit_und_flag", UNDERRUN, UND_EN);
        tick();

        // Fill FIFO, push while full, then play out
        for (int i = 0; i < DEPTH; i++) push(i + 1, 4'(i + 3), i == DEPTH - 1);
        @(negedge CLK); chk("lit_full_ready", in_ready, 1'b0); chk("lit_full_cnt", fifo_cnt, DEPTH);
        push(9, 4'hC, 1);
        @(negedge CLK); chk("lit_full_cnt2", fifo_cnt, DEPTH);
        start();
        repeat (40) tick();

        // Abort mid-run with three queued entries
        push(5, 4'h3, 0); push(5, 4'h6, 0); push(5, 4'h9, 0); push(5, 4'hC, 1);
        start();
        tick();
        @(negedge CLK); chk("lit_abt_cnt_pre", fifo_cnt, 3);
        ABORT = 1; tick(); ABORT = 0;
        @(negedge CLK);
        chk("lit_abt_out", OUT, 4'h0); chk("lit_abt_cnt", fifo_cnt, 0); chk("lit_abt_busy", BUSY, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); chk("lit_abt_nodone", DONE, 1'b0);
        end
        tick();
        push(2, 4'h3, 1);
        start();
        @(negedge CLK); chk("lit_post_abt0", OUT, 4'h3);
        @(negedge CLK); chk("lit_post_abt1", OUT, 4'h3);
        @(negedge CLK); chk("lit_post_abt2", OUT, 4'h0); chk("lit_post_abt_done", DONE, 1'b1);
        tick();

        // Channel 2 routed to its mux_in[4]; sel change mid-run ignored
        mux_sel = 16'h0500;
        push(6, 4'hF, 1);
        start();
        mux_sel = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            mux_in = {$urandom, $urandom};
            @(negedge CLK);
            chk("lit_mux_ch2", OUT[2], mux_in[MIW*2 + 4]);
            chk("lit_mux_ch0", OUT[0], 1'b1);
        end
        repeat (4) tick();

        // Random phase
        for (int cyc = 0; cyc < 4000; cyc++) begin
            RST      = ($urandom_range(0, 999) == 0);
            ABORT    = ($urandom_range(0, 63) == 0);
            START    = ($urandom_range(0, 3) == 0);
            in_valid = $urandom_range(0, 1);
            in_len   = ($urandom_range(0, 49) == 0) ? 24'hFFFFFF : DW'($urandom_range(0, 6));
            in_pol   = 4'($urandom);
            in_last  = ($urandom_range(0, 3) == 0);
            mux_sel  = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            mux_in   = {$urandom, $urandom};
            tick();
        end
        RST = 0; ABORT = 0; START = 0; in_valid = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
